// File: rtl/regfile_rd_port.sv
// One combinational read port: stored value, optional same-cycle write forwarding,
// and the hardwired-zero override.
module regfile_rd_port #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NWRITE   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int ADDR    = $clog2(DEPTH)
) (
    input  logic [ADDR-1:0]               addr,
    input  logic [DEPTH-1:0][WIDTH-1:0]   mem,
    input  logic [DEPTH-1:0]              busy,
    input  logic [NWRITE-1:0]             wen,
    input  logic [NWRITE*ADDR-1:0]        wreg,
    input  logic [NWRITE*WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic                          rbusy
);

    logic is_zero;
    assign is_zero = (ZERO_REG != 0) && (addr == '0);

    // Ascending scan so the highest-indexed matching write port is the one forwarded.
    always_comb begin
        rdata = mem[addr];
        rbusy = busy[addr];
        if (BYPASS != 0) begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wen[j] && (wreg[j*ADDR +: ADDR] == addr)) begin
                    rdata = wdata[j*WIDTH +: WIDTH];
                    rbusy = 1'b0;
                end
            end
        end
        if (is_zero) begin
            rdata = '0;
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-register busy scoreboard for RAW/WAW
// hazard detection at issue.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int ADDR    = $clog2(DEPTH),
    localparam int CNTW    = ADDR + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREAD*ADDR-1:0]    rreg,
    output logic [NREAD*WIDTH-1:0]   rdata,
    output logic [NREAD-1:0]         rbusy,
    input  logic [NWRITE-1:0]        wen,
    input  logic [NWRITE*ADDR-1:0]   wreg,
    input  logic [NWRITE*WIDTH-1:0]  wdata,
    input  logic                     alloc_en,
    input  logic [ADDR-1:0]          alloc_reg,
    output logic                     alloc_ok,
    output logic [CNTW-1:0]          busy_cnt
);

    logic [DEPTH-1:0][WIDTH-1:0] mem, mem_nxt;
    logic [DEPTH-1:0]            busy, busy_nxt;
    logic                        alloc_hit, alloc_zero;

    function automatic logic [CNTW-1:0] popcnt(input logic [DEPTH-1:0] v);
        logic [CNTW-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) n = n + CNTW'(v[i]);
        return n;
    endfunction

    genvar k;
    generate
        for (k = 0; k < NREAD; k++) begin : g_rd
            regfile_rd_port #(
                .WIDTH(WIDTH), .DEPTH(DEPTH), .NWRITE(NWRITE),
                .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
            ) u_rd (
                .addr  (rreg[k*ADDR +: ADDR]),
                .mem   (mem),
                .busy  (busy),
                .wen   (wen),
                .wreg  (wreg),
                .wdata (wdata),
                .rdata (rdata[k*WIDTH +: WIDTH]),
                .rbusy (rbusy[k])
            );
        end
    endgenerate

    assign alloc_zero = (ZERO_REG != 0) && (alloc_reg == '0);

    always_comb begin
        alloc_hit = 1'b0;
        for (int j = 0; j < NWRITE; j++)
            if (wen[j] && (wreg[j*ADDR +: ADDR] == alloc_reg)) alloc_hit = 1'b1;
    end

    // A same-cycle write retires the old producer, so the slot may be re-allocated.
    assign alloc_ok = alloc_en && (alloc_zero || !busy[alloc_reg] || alloc_hit);

    always_comb begin
        mem_nxt  = mem;
        busy_nxt = busy;
        for (int j = 0; j < NWRITE; j++) begin
            if (wen[j] && !((ZERO_REG != 0) && (wreg[j*ADDR +: ADDR] == '0))) begin
                mem_nxt[wreg[j*ADDR +: ADDR]]  = wdata[j*WIDTH +: WIDTH];
                busy_nxt[wreg[j*ADDR +: ADDR]] = 1'b0;
            end
        end
        // New producer supersedes a retiring one on the same register.
        if (alloc_ok && !alloc_zero) busy_nxt[alloc_reg] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem      <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            mem      <= mem_nxt;
            busy     <= busy_nxt;
            busy_cnt <= popcnt(busy_nxt);
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp: instance a (BYPASS=1, ZERO_REG=1) and instance b
// (BYPASS=0, ZERO_REG=0) share stimulus and are checked against an array model.
module tb_regfile_mp;
    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int A  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*A-1:0]   rreg;
    logic [NW-1:0]     wen;
    logic [NW*A-1:0]   wreg;
    logic [NW*W-1:0]   wdata;
    logic              alloc_en;
    logic [A-1:0]      alloc_reg;

    logic [NR*W-1:0]   rdata_a, rdata_b;
    logic [NR-1:0]     rbusy_a, rbusy_b;
    logic              alloc_ok_a, alloc_ok_b;
    logic [A:0]        busy_cnt_a, busy_cnt_b;

    int checks = 0;
    int errors = 0;
    bit armed  = 0;

    // Model state, index 0 = instance a, 1 = instance b
    logic [W-1:0] mm [2][D];
    bit           mb [2][D];

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .NWRITE(NW), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .rreg(rreg), .rdata(rdata_a), .rbusy(rbusy_a),
        .wen(wen), .wreg(wreg), .wdata(wdata), .alloc_en(alloc_en), .alloc_reg(alloc_reg),
        .alloc_ok(alloc_ok_a), .busy_cnt(busy_cnt_a));

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .NWRITE(NW), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .rreg(rreg), .rdata(rdata_b), .rbusy(rbusy_b),
        .wen(wen), .wreg(wreg), .wdata(wdata), .alloc_en(alloc_en), .alloc_reg(alloc_reg),
        .alloc_ok(alloc_ok_b), .busy_cnt(busy_cnt_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wr_reg(input int j);
        return int'(wreg[j*A +: A]);
    endfunction

    // Reads: zero rule first, then newest same-cycle writer (searched from the top port), then storage.
    function automatic logic [W-1:0] exp_rdata(input int c, input int k);
        int r = int'(rreg[k*A +: A]);
        if (c == 0 && r == 0) return '0;
        if (c == 0)
            for (int j = NW-1; j >= 0; j--)
                if (wen[j] && wr_reg(j) == r) return wdata[j*W +: W];
        return mm[c][r];
    endfunction

    function automatic bit exp_rbusy(input int c, input int k);
        int r = int'(rreg[k*A +: A]);
        if (c == 0 && r == 0) return 1'b0;
        if (c == 0)
            for (int j = 0; j < NW; j++)
                if (wen[j] && wr_reg(j) == r) return 1'b0;
        return mb[c][r];
    endfunction

    function automatic bit exp_alloc_ok(input int c);
        int r = int'(alloc_reg);
        if (!alloc_en) return 1'b0;
        if (c == 0 && r == 0) return 1'b1;
        if (!mb[c][r]) return 1'b1;
        for (int j = 0; j < NW; j++)
            if (wen[j] && wr_reg(j) == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_cnt(input int c);
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(mb[c][i]);
        return n;
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (!reset) begin
                for (int i = 0; i < D; i++) begin
                    mm[c][i] = '0;
                    mb[c][i] = 1'b0;
                end
            end else begin
                bit ok;
                ok = exp_alloc_ok(c);
                for (int j = 0; j < NW; j++)
                    if (wen[j] && !(c == 0 && wr_reg(j) == 0)) begin
                        mm[c][wr_reg(j)] = wdata[j*W +: W];
                        mb[c][wr_reg(j)] = 1'b0;
                    end
                if (ok && !(c == 0 && alloc_reg == '0)) mb[c][alloc_reg] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < NR; k++) begin
                chk($sformatf("a rdata%0d", k), rdata_a[k*W +: W], exp_rdata(0, k));
                chk($sformatf("a rbusy%0d", k), 32'(rbusy_a[k]), 32'(exp_rbusy(0, k)));
                chk($sformatf("b rdata%0d", k), rdata_b[k*W +: W], exp_rdata(1, k));
                chk($sformatf("b rbusy%0d", k), 32'(rbusy_b[k]), 32'(exp_rbusy(1, k)));
            end
            chk("a alloc_ok", 32'(alloc_ok_a), 32'(exp_alloc_ok(0)));
            chk("b alloc_ok", 32'(alloc_ok_b), 32'(exp_alloc_ok(1)));
            chk("a busy_cnt", 32'(busy_cnt_a), 32'(exp_cnt(0)));
            chk("b busy_cnt", 32'(busy_cnt_b), 32'(exp_cnt(1)));
        end
    end

    task automatic idle();
        reset = 1'b1; rreg = '0; wen = '0; wreg = '0; wdata = '0;
        alloc_en = 1'b0; alloc_reg = '0;
    endtask

    task automatic next();
        @(posedge clk); #1; idle();
    endtask

    task automatic wr(input int j, input int r, input logic [W-1:0] d);
        wen[j] = 1'b1;
        wreg[j*A +: A] = A'(r);
        wdata[j*W +: W] = d;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        @(posedge clk); #1;
        armed = 1;
        reset = 1'b0;
        next();
        @(negedge clk);
        chk("lit reset cnt", 32'(busy_cnt_a), 32'd0);

        // Reset wipes a written value
        next(); wr(0, 5, 32'hDEADBEEF);
        next(); rreg[A-1:0] = 5;
        @(negedge clk); chk("lit r5 written", rdata_a[W-1:0], 32'hDEADBEEF);
        next(); reset = 1'b0; rreg[A-1:0] = 5;
        next(); rreg[A-1:0] = 5;
        @(negedge clk);
        chk("lit r5 after reset", rdata_a[W-1:0], 32'h0);
        chk("lit r5 busy after reset", 32'(rbusy_a[0]), 32'd0);
        chk("lit cnt after reset", 32'(busy_cnt_a), 32'd0);

        // Zero register
        next(); wr(0, 0, 32'h1234);
        @(negedge clk); chk("lit a r0 bypass", rdata_a[W-1:0], 32'h0);
        next();
        @(negedge clk);
        chk("lit a r0", rdata_a[W-1:0], 32'h0);
        chk("lit b r0", rdata_b[W-1:0], 32'h1234);

        // Write conflict and bypass
        next(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rreg[A-1:0] = 7;
        @(negedge clk);
        chk("lit a bypass r7", rdata_a[W-1:0], 32'h22);
        chk("lit b old r7", rdata_b[W-1:0], 32'h0);
        next(); rreg[A-1:0] = 7;
        @(negedge clk);
        chk("lit b r7 next", rdata_b[W-1:0], 32'h22);

        // RAW scoreboard
        next(); alloc_en = 1'b1; alloc_reg = 3;
        @(negedge clk); chk("lit alloc r3", 32'(alloc_ok_a), 32'd1);
        next(); rreg[A-1:0] = 3;
        @(negedge clk);
        chk("lit r3 busy", 32'(rbusy_a[0]), 32'd1);
        chk("lit cnt 1", 32'(busy_cnt_a), 32'd1);
        next(); wr(1, 3, 32'hAB); rreg[A-1:0] = 3;
        @(negedge clk);
        chk("lit r3 bypass busy", 32'(rbusy_a[0]), 32'd0);
        chk("lit r3 bypass data", rdata_a[W-1:0], 32'hAB);
        next();
        @(negedge clk); chk("lit cnt 0", 32'(busy_cnt_a), 32'd0);

        // WAW stall
        next(); alloc_en = 1'b1; alloc_reg = 4;
        next(); alloc_en = 1'b1; alloc_reg = 4;
        @(negedge clk); chk("lit waw refused", 32'(alloc_ok_a), 32'd0);
        next(); alloc_en = 1'b1; alloc_reg = 4; wr(0, 4, 32'h44);
        @(negedge clk);
        chk("lit cnt held", 32'(busy_cnt_a), 32'd1);
        chk("lit waw with write", 32'(alloc_ok_a), 32'd1);
        next(); rreg[A-1:0] = 4;
        @(negedge clk);
        chk("lit r4 still busy", 32'(rbusy_a[0]), 32'd1);
        chk("lit cnt still 1", 32'(busy_cnt_a), 32'd1);

        // Fill every non-zero register
        for (int r = 1; r < D; r++) begin
            next(); alloc_en = 1'b1; alloc_reg = A'(r);
        end
        next(); alloc_en = 1'b1; alloc_reg = 9;
        @(negedge clk);
        chk("lit cnt full", 32'(busy_cnt_a), 32'd31);
        chk("lit full refused", 32'(alloc_ok_a), 32'd0);
        next(); reset = 1'b0;
        next();
        @(negedge clk); chk("lit cnt after mid reset", 32'(busy_cnt_a), 32'd0);

        // Random traffic; small address range most of the time to force collisions
        repeat (3000) begin
            next();
            reset = ($urandom_range(0, 99) != 0);
            for (int k = 0; k < NR; k++)
                rreg[k*A +: A] = A'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, D-1));
            for (int j = 0; j < NW; j++) begin
                wen[j] = ($urandom_range(0, 2) == 0);
                wreg[j*A +: A] = A'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, D-1));
                wdata[j*W +: W] = $urandom;
            end
            alloc_en  = ($urandom_range(0, 1) == 0);
            alloc_reg = A'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, D-1));
        end
        next();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
